register_file_mp: RTL

- Parametrised multi-port register file for the single-cycle and pipelined datapaths.
- Provides NUM_READ combinational read ports and two synchronous write ports.
- Optionally hardwires register 0 to zero and forwards same-cycle writes to readers.
- Contains a pending-write scoreboard that issue logic uses to detect RAW and WAW hazards.

---
 rtl/register_file_mp_if.sv | 29 ++
 rtl/register_file_mp.sv | 102 ++++++++++
 2 files changed

// File: rtl/register_file_mp_if.sv
// Bus bundle for register_file_mp: read ports, two write ports and the issue/scoreboard handshake.
// "master" is the datapath/issue side, "slave" is the register file.
interface register_file_mp_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_READ = 2
);
  logic [NUM_READ*ADDR_W-1:0] readReg;
  logic [NUM_READ*DATA_W-1:0] readData;
  logic [NUM_READ-1:0]        readBusy;
  logic [1:0]                 writeEnable;
  logic [2*ADDR_W-1:0]        writeReg;
  logic [2*DATA_W-1:0]        writeData;
  logic [1:0]                 writeClear;
  logic                       issueValid;
  logic [ADDR_W-1:0]          issueReg;
  logic                       issueStall;
  logic [ADDR_W:0]            pendingCount;

  modport master (
    output readReg, writeEnable, writeReg, writeData, writeClear, issueValid, issueReg,
    input  readData, readBusy, issueStall, pendingCount
  );

  modport slave (
    input  readReg, writeEnable, writeReg, writeData, writeClear, issueValid, issueReg,
    output readData, readBusy, issueStall, pendingCount
  );
endinterface

// File: rtl/register_file_mp.sv
// Multi-port register file: NUM_READ combinational reads, two synchronous writes with optional
// same-cycle bypass, and a pending-write scoreboard with population count for hazard detection.
module register_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  register_file_mp_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic [DEPTH-1:0]  pending_next;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;

  logic [ADDR_W-1:0] wa0, wa1, ir;
  logic [DATA_W-1:0] wd0, wd1;
  logic              wr_ok0, wr_ok1, clr_ok0, clr_ok1;
  logic              stall, set_ok, fall0, fall1;

  logic [NUM_READ*DATA_W-1:0] rd_data;
  logic [NUM_READ-1:0]        rd_busy;

  assign wa0 = bus.writeReg[0 +: ADDR_W];
  assign wa1 = bus.writeReg[ADDR_W +: ADDR_W];
  assign wd0 = bus.writeData[0 +: DATA_W];
  assign wd1 = bus.writeData[DATA_W +: DATA_W];
  assign ir  = bus.issueReg;

  // Writes to r0 are discarded entirely when it is hardwired, including for bypass.
  assign wr_ok0 = bus.writeEnable[0] && !(ZERO_REG != 0 && wa0 == '0);
  assign wr_ok1 = bus.writeEnable[1] && !(ZERO_REG != 0 && wa1 == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) regs[k] <= '0;
    end else begin
      if (wr_ok0) regs[wa0] <= wd0;
      if (wr_ok1) regs[wa1] <= wd1;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] dat;
      ra  = bus.readReg[i*ADDR_W +: ADDR_W];
      dat = regs[ra];
      if (BYPASS != 0) begin
        if (wr_ok0 && wa0 == ra) dat = wd0;
        if (wr_ok1 && wa1 == ra) dat = wd1;
      end
      if (ZERO_REG != 0 && ra == '0) dat = '0;
      rd_data[i*DATA_W +: DATA_W] = dat;
      rd_busy[i] = pending[ra] && !(ZERO_REG != 0 && ra == '0);
    end
  end

  assign bus.readData = rd_data;
  assign bus.readBusy = rd_busy;

  // Stall looks only at registered state, so a same-cycle retire does not unblock the issue.
  assign stall   = bus.issueValid && pending[ir];
  assign set_ok  = bus.issueValid && !stall && !(ZERO_REG != 0 && ir == '0);
  assign clr_ok0 = bus.writeEnable[0] && bus.writeClear[0];
  assign clr_ok1 = bus.writeEnable[1] && bus.writeClear[1];

  // A set can only target a clear bit, so it never cancels a falling transition.
  assign fall0 = clr_ok0 && pending[wa0];
  assign fall1 = clr_ok1 && pending[wa1] && !(clr_ok0 && wa0 == wa1);

  always_comb begin
    pending_next = pending;
    if (clr_ok0) pending_next[wa0] = 1'b0;
    if (clr_ok1) pending_next[wa1] = 1'b0;
    if (set_ok)  pending_next[ir]  = 1'b1;
  end

  assign count_next = count + CNT_W'(set_ok) - CNT_W'(fall0) - CNT_W'(fall1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
      count   <= '0;
    end else begin
      pending <= pending_next;
      count   <= count_next;
    end
  end

  assign bus.issueStall   = stall;
  assign bus.pendingCount = count;
endmodule
